lcd_ctrl_p: RTL and testbench

Parametrised successor of the team's 8x8 LCD image controller. On reset it loads an IMG_W x IMG_H image from IROM into an internal pixel array. It then executes 2x2-window commands against that array and streams the image to IRAM on a WRITE command. Unlike the first generation, it supports any power-of-two geometry and pixel width, adds HOME and INVERT commands, and returns to command mode after each WRITE so multiple frames can be written without reset.

---
 rtl/lcd_ctrl_pkg.sv | 38 +++
 rtl/lcd_win_alu.sv | 58 +++++
 rtl/lcd_ctrl_p.sv | 204 ++++++++++++++++++++
 tb/tb_lcd_ctrl_p.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the parametrised LCD image controller.
//   - 4-bit command codes accepted on cmd
//   - controller state encoding
//   - helpers giving the reset (HOME) position of the 2x2 window origin
package lcd_ctrl_pkg;

   localparam logic [3:0] CMD_WRITE    = 4'd0;
   localparam logic [3:0] CMD_UP       = 4'd1;
   localparam logic [3:0] CMD_DOWN     = 4'd2;
   localparam logic [3:0] CMD_LEFT     = 4'd3;
   localparam logic [3:0] CMD_RIGHT    = 4'd4;
   localparam logic [3:0] CMD_MAX      = 4'd5;
   localparam logic [3:0] CMD_MIN      = 4'd6;
   localparam logic [3:0] CMD_AVG      = 4'd7;
   localparam logic [3:0] CMD_ROT_CCW  = 4'd8;
   localparam logic [3:0] CMD_ROT_CW   = 4'd9;
   localparam logic [3:0] CMD_MIRROR_X = 4'd10;
   localparam logic [3:0] CMD_MIRROR_Y = 4'd11;
   localparam logic [3:0] CMD_HOME     = 4'd12;
   localparam logic [3:0] CMD_INVERT   = 4'd13;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_READY = 2'd1,
      ST_EXEC  = 2'd2,
      ST_STORE = 2'd3
   } state_t;

   // Window origin sits just above/left of the image centre.
   function automatic int unsigned home_x(input int unsigned img_w);
      return img_w / 32'd2 - 32'd1;
   endfunction

   function automatic int unsigned home_y(input int unsigned img_h);
      return img_h / 32'd2 - 32'd1;
   endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator.
//   cmd        : command code (only window-modifying codes change data)
//   p0..p3     : current window pixels (p0 top-left, p1 top-right,
//                p2 bottom-left, p3 bottom-right)
//   q0..q3     : new window pixels; equal to p0..p3 for any other command
module lcd_win_alu
   import lcd_ctrl_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic [3:0]    cmd,
   input  logic [DW-1:0] p0,
   input  logic [DW-1:0] p1,
   input  logic [DW-1:0] p2,
   input  logic [DW-1:0] p3,
   output logic [DW-1:0] q0,
   output logic [DW-1:0] q1,
   output logic [DW-1:0] q2,
   output logic [DW-1:0] q3
);

   logic [DW-1:0] max01_s, max23_s, max_s;
   logic [DW-1:0] min01_s, min23_s, min_s;
   logic [DW+1:0] sum_s;
   logic [DW-1:0] avg_s;

   // Reductions over the window: max, min and truncated mean.
   always_comb begin
      max01_s = (p0 > p1) ? p0 : p1;
      max23_s = (p2 > p3) ? p2 : p3;
      max_s   = (max01_s > max23_s) ? max01_s : max23_s;
      min01_s = (p0 < p1) ? p0 : p1;
      min23_s = (p2 < p3) ? p2 : p3;
      min_s   = (min01_s < min23_s) ? min01_s : min23_s;
      sum_s   = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
      avg_s   = sum_s[DW+1:2];
   end

   // Per-command selection of the new window contents.
   always_comb begin
      q0 = p0;
      q1 = p1;
      q2 = p2;
      q3 = p3;
      case (cmd)
         CMD_MAX:      begin q0 = max_s; q1 = max_s; q2 = max_s; q3 = max_s; end
         CMD_MIN:      begin q0 = min_s; q1 = min_s; q2 = min_s; q3 = min_s; end
         CMD_AVG:      begin q0 = avg_s; q1 = avg_s; q2 = avg_s; q3 = avg_s; end
         CMD_ROT_CCW:  begin q0 = p1; q1 = p3; q2 = p0; q3 = p2; end
         CMD_ROT_CW:   begin q0 = p2; q1 = p0; q2 = p3; q3 = p1; end
         CMD_MIRROR_X: begin q0 = p2; q1 = p3; q2 = p0; q3 = p1; end
         CMD_MIRROR_Y: begin q0 = p1; q1 = p0; q2 = p3; q3 = p2; end
         CMD_INVERT:   begin q0 = ~p0; q1 = ~p1; q2 = ~p2; q3 = ~p3; end
         default:      begin q0 = p0; q1 = p1; q2 = p2; q3 = p3; end
      endcase
   end

endmodule

// File: rtl/lcd_ctrl_p.sv
// Parametrised LCD image controller.
// Loads an IMG_W x IMG_H image from IROM after reset, executes 2x2-window
// commands on it and streams it to IRAM on WRITE, returning to command mode.
//   clk, reset          : clock and synchronous active-high reset
//   cmd, cmd_valid      : command code and strobe (taken only when busy=0)
//   IROM_Q/IROM_rd/IROM_A : image ROM, read data one cycle after address
//   IRAM_valid/D/A      : image RAM write port
//   busy                : high while a command cannot be accepted
//   done                : one-cycle pulse after a WRITE stream
module lcd_ctrl_p
   import lcd_ctrl_pkg::*;
#(
   parameter int DW    = 8,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int AW    = $clog2(IMG_W * IMG_H)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    cmd,
   input  logic          cmd_valid,
   input  logic [DW-1:0] IROM_Q,
   output logic          IROM_rd,
   output logic [AW-1:0] IROM_A,
   output logic          IRAM_valid,
   output logic [DW-1:0] IRAM_D,
   output logic [AW-1:0] IRAM_A,
   output logic          busy,
   output logic          done
);

   localparam int            XW     = $clog2(IMG_W);
   localparam int            YW     = $clog2(IMG_H);
   localparam int            N      = IMG_W * IMG_H;
   localparam logic [AW:0]   N_C    = (AW+1)'(N);
   localparam logic [XW-1:0] HOME_X = XW'(home_x(IMG_W));
   localparam logic [YW-1:0] HOME_Y = YW'(home_y(IMG_H));
   localparam logic [XW-1:0] X_LIM  = XW'(IMG_W - 2);
   localparam logic [YW-1:0] Y_LIM  = YW'(IMG_H - 2);

   state_t        state_r, state_n;
   logic [AW:0]   cnt_r, cnt_n;          // LOAD cycle count / STORE beat index
   logic [3:0]    cmd_r, cmd_n;
   logic [XW-1:0] x0_r, x0_n;
   logic [YW-1:0] y0_r, y0_n;
   logic          rom_rd_n, ram_valid_n, busy_n, done_n;
   logic [AW-1:0] rom_a_n, ram_a_n;
   logic [DW-1:0] ram_d_n;

   logic          cap_valid_r;           // IROM_Q holds the pixel at cap_addr_r
   logic [AW-1:0] cap_addr_r;
   logic [DW-1:0] pix_r [0:N-1];

   logic [AW-1:0] a0_s, a1_s, a2_s, a3_s;
   logic [DW-1:0] q0_s, q1_s, q2_s, q3_s;

   // Power-of-two width makes raster address y*IMG_W+x a plain concatenation.
   assign a0_s = {y0_r, x0_r};
   assign a1_s = {y0_r, x0_r + XW'(1'b1)};
   assign a2_s = {y0_r + YW'(1'b1), x0_r};
   assign a3_s = {y0_r + YW'(1'b1), x0_r + XW'(1'b1)};

   lcd_win_alu #(.DW(DW)) u_alu (
      .cmd (cmd_r),
      .p0  (pix_r[a0_s]),
      .p1  (pix_r[a1_s]),
      .p2  (pix_r[a2_s]),
      .p3  (pix_r[a3_s]),
      .q0  (q0_s),
      .q1  (q1_s),
      .q2  (q2_s),
      .q3  (q3_s)
   );

   // Next-state and next-output logic of the controller.
   always_comb begin
      state_n     = state_r;
      cnt_n       = cnt_r;
      cmd_n       = cmd_r;
      x0_n        = x0_r;
      y0_n        = y0_r;
      rom_rd_n    = 1'b0;
      rom_a_n     = IROM_A;
      ram_valid_n = 1'b0;
      ram_a_n     = IRAM_A;
      ram_d_n     = IRAM_D;
      busy_n      = busy;
      done_n      = 1'b0;
      case (state_r)
         ST_LOAD: begin
            busy_n = 1'b1;
            cnt_n  = cnt_r + (AW+1)'(1'b1);
            if (cnt_r < N_C) begin
               rom_rd_n = 1'b1;
               rom_a_n  = cnt_r[AW-1:0];
            end else if (cnt_r == N_C) begin
               // Last address issued; wait one more cycle for its data.
               rom_rd_n = 1'b0;
            end else begin
               state_n = ST_READY;
               busy_n  = 1'b0;
               cnt_n   = '0;
            end
         end
         ST_READY: begin
            busy_n = 1'b0;
            if (cmd_valid) begin
               cmd_n   = cmd;
               busy_n  = 1'b1;
               cnt_n   = '0;
               state_n = (cmd == CMD_WRITE) ? ST_STORE : ST_EXEC;
            end else begin
               state_n = ST_READY;
            end
         end
         ST_EXEC: begin
            busy_n  = 1'b0;
            state_n = ST_READY;
            case (cmd_r)
               CMD_UP:    y0_n = (y0_r != '0)   ? y0_r - YW'(1'b1) : y0_r;
               CMD_DOWN:  y0_n = (y0_r < Y_LIM) ? y0_r + YW'(1'b1) : y0_r;
               CMD_LEFT:  x0_n = (x0_r != '0)   ? x0_r - XW'(1'b1) : x0_r;
               CMD_RIGHT: x0_n = (x0_r < X_LIM) ? x0_r + XW'(1'b1) : x0_r;
               CMD_HOME:  begin x0_n = HOME_X; y0_n = HOME_Y; end
               default:   begin x0_n = x0_r; y0_n = y0_r; end
            endcase
         end
         ST_STORE: begin
            if (cnt_r < N_C) begin
               busy_n      = 1'b1;
               ram_valid_n = 1'b1;
               ram_a_n     = cnt_r[AW-1:0];
               ram_d_n     = pix_r[cnt_r[AW-1:0]];
               cnt_n       = cnt_r + (AW+1)'(1'b1);
            end else begin
               busy_n  = 1'b0;
               done_n  = 1'b1;
               state_n = ST_READY;
            end
         end
         default: begin
            state_n = ST_LOAD;
            cnt_n   = '0;
         end
      endcase
   end

   // Controller state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_LOAD;
         cnt_r      <= '0;
         cmd_r      <= CMD_WRITE;
         x0_r       <= HOME_X;
         y0_r       <= HOME_Y;
         IROM_rd    <= 1'b0;
         IROM_A     <= '0;
         IRAM_valid <= 1'b0;
         IRAM_A     <= '0;
         IRAM_D     <= '0;
         busy       <= 1'b1;
         done       <= 1'b0;
      end else begin
         state_r    <= state_n;
         cnt_r      <= cnt_n;
         cmd_r      <= cmd_n;
         x0_r       <= x0_n;
         y0_r       <= y0_n;
         IROM_rd    <= rom_rd_n;
         IROM_A     <= rom_a_n;
         IRAM_valid <= ram_valid_n;
         IRAM_A     <= ram_a_n;
         IRAM_D     <= ram_d_n;
         busy       <= busy_n;
         done       <= done_n;
      end
   end

   // Tracks which address the ROM is currently returning.
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_valid_r <= 1'b0;
         cap_addr_r  <= '0;
      end else begin
         cap_valid_r <= IROM_rd;
         cap_addr_r  <= IROM_A;
      end
   end

   // Pixel array: ROM capture during LOAD, window write-back in EXEC.
   // Non-window commands write back unchanged pixels, which is harmless.
   always_ff @(posedge clk) begin
      if (!reset && cap_valid_r) begin
         pix_r[cap_addr_r] <= IROM_Q;
      end
      if (!reset && (state_r == ST_EXEC)) begin
         pix_r[a0_s] <= q0_s;
         pix_r[a1_s] <= q1_s;
         pix_r[a2_s] <= q2_s;
         pix_r[a3_s] <= q3_s;
      end
   end

endmodule

// File: tb/tb_lcd_ctrl_p.sv
// Self-checking bench for lcd_ctrl_p: an 8x8/DW=8 instance checked against a
// behavioural image model (directed + random commands) and a 16x4/DW=10
// instance checked with directed steps.
module tb_lcd_ctrl_p;
   import lcd_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ---------------- instance A: 8x8, DW=8 ----------------
   logic [3:0] a_cmd;
   logic       a_cmd_valid;
   logic [7:0] a_irom_q;
   logic       a_irom_rd;
   logic [5:0] a_irom_a;
   logic       a_iram_valid;
   logic [7:0] a_iram_d;
   logic [5:0] a_iram_a;
   logic       a_busy, a_done;

   lcd_ctrl_p #(.DW(8), .IMG_W(8), .IMG_H(8)) dut_a (
      .clk(clk), .reset(reset), .cmd(a_cmd), .cmd_valid(a_cmd_valid),
      .IROM_Q(a_irom_q), .IROM_rd(a_irom_rd), .IROM_A(a_irom_a),
      .IRAM_valid(a_iram_valid), .IRAM_D(a_iram_d), .IRAM_A(a_iram_a),
      .busy(a_busy), .done(a_done)
   );

   // ---------------- instance B: 16x4, DW=10 ----------------
   logic [3:0] b_cmd;
   logic       b_cmd_valid;
   logic [9:0] b_irom_q;
   logic       b_irom_rd;
   logic [5:0] b_irom_a;
   logic       b_iram_valid;
   logic [9:0] b_iram_d;
   logic [5:0] b_iram_a;
   logic       b_busy, b_done;

   lcd_ctrl_p #(.DW(10), .IMG_W(16), .IMG_H(4)) dut_b (
      .clk(clk), .reset(reset), .cmd(b_cmd), .cmd_valid(b_cmd_valid),
      .IROM_Q(b_irom_q), .IROM_rd(b_irom_rd), .IROM_A(b_irom_a),
      .IRAM_valid(b_iram_valid), .IRAM_D(b_iram_d), .IRAM_A(b_iram_a),
      .busy(b_busy), .done(b_done)
   );

   // ROM / RAM models
   logic [7:0] rom_a [64];
   logic [9:0] rom_b [64];
   logic [7:0] cap_a [64];
   logic [9:0] cap_b [64];

   always @(posedge clk) begin
      if (a_irom_rd === 1'b1) a_irom_q <= rom_a[a_irom_a];
      if (b_irom_rd === 1'b1) b_irom_q <= rom_b[b_irom_a];
      if (a_iram_valid === 1'b1) cap_a[a_iram_a] <= a_iram_d;
      if (b_iram_valid === 1'b1) cap_b[b_iram_a] <= b_iram_d;
   end

   // Reference image models
   int mpix [64];
   int mx, my;
   int bpix [64];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Spec-level effect of one command on the 8x8 model image.
   task automatic model_apply(input int c);
      int id [4];
      int v  [4];
      int nv [4];
      int m;
      id[0] = my * 8 + mx;
      id[1] = id[0] + 1;
      id[2] = id[0] + 8;
      id[3] = id[0] + 9;
      for (int k = 0; k < 4; k++) begin
         v[k]  = mpix[id[k]];
         nv[k] = v[k];
      end
      case (c)
         1: if (my > 0) my = my - 1;
         2: if (my < 6) my = my + 1;
         3: if (mx > 0) mx = mx - 1;
         4: if (mx < 6) mx = mx + 1;
         5: begin
            m = v[0];
            for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
            for (int k = 0; k < 4; k++) nv[k] = m;
         end
         6: begin
            m = v[0];
            for (int k = 1; k < 4; k++) if (v[k] < m) m = v[k];
            for (int k = 0; k < 4; k++) nv[k] = m;
         end
         7: begin
            m = (v[0] + v[1] + v[2] + v[3]) / 4;
            for (int k = 0; k < 4; k++) nv[k] = m;
         end
         8:  nv = '{v[1], v[3], v[0], v[2]};
         9:  nv = '{v[2], v[0], v[3], v[1]};
         10: nv = '{v[2], v[3], v[0], v[1]};
         11: nv = '{v[1], v[0], v[3], v[2]};
         12: begin mx = 3; my = 3; end
         13: for (int k = 0; k < 4; k++) nv[k] = 255 - v[k];
         default: ;
      endcase
      for (int k = 0; k < 4; k++) mpix[id[k]] = nv[k];
   endtask

   // Reset both instances for n cycles, check reset values and load timing.
   task automatic do_reset(input int n);
      int fall;
      @(negedge clk);
      reset = 1'b1;
      a_cmd_valid = 1'b0;
      b_cmd_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      chk("rst_busy", 32'(a_busy), 32'd1);
      chk("rst_rom", 32'({a_irom_rd, a_irom_a}), 32'd0);
      chk("rst_ram", 32'({a_iram_valid, a_iram_a, a_iram_d, a_done}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      fall = 0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) chk("load_first_addr", 32'({a_irom_rd, a_irom_a}), 32'h40);
         if (a_busy === 1'b0) begin
            fall = k;
            break;
         end
      end
      chk("load_len", 32'(fall), 32'd66);
      chk("b_load_len", 32'(b_busy), 32'd0);
      mx = 3;
      my = 3;
      for (int i = 0; i < 64; i++) mpix[i] = int'(rom_a[i]);
   endtask

   task automatic a_exec(input int c);
      @(negedge clk);
      a_cmd = 4'(c);
      a_cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("a_acc_busy", 32'(a_busy), 32'd1);
      @(negedge clk);
      a_cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("a_exec_ready", 32'(a_busy), 32'd0);
      model_apply(c);
   endtask

   task automatic a_write();
      @(negedge clk);
      a_cmd = CMD_WRITE;
      a_cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("a_wr_acc", 32'({a_busy, a_iram_valid}), 32'b10);
      @(negedge clk);
      a_cmd_valid = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk);
         #1;
         chk("a_beat", 32'({a_iram_valid, a_iram_a, a_iram_d}),
             32'({1'b1, 6'(i), 8'(mpix[i])}));
      end
      @(posedge clk);
      #1;
      chk("a_wr_done", 32'({a_iram_valid, a_done, a_busy}), 32'b010);
      @(posedge clk);
      #1;
      chk("a_done_once", 32'(a_done), 32'd0);
   endtask

   task automatic b_exec(input logic [3:0] c);
      @(negedge clk);
      b_cmd = c;
      b_cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("b_acc_busy", 32'(b_busy), 32'd1);
      @(negedge clk);
      b_cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("b_exec_ready", 32'(b_busy), 32'd0);
   endtask

   task automatic b_write();
      @(negedge clk);
      b_cmd = CMD_WRITE;
      b_cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      b_cmd_valid = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk);
         #1;
         chk("b_beat", 32'({b_iram_valid, b_iram_a, b_iram_d}),
             32'({1'b1, 6'(i), 10'(bpix[i])}));
      end
      @(posedge clk);
      #1;
      chk("b_wr_done", 32'({b_iram_valid, b_done, b_busy}), 32'b010);
   endtask

   initial begin
      reset = 1'b1;
      a_cmd = 4'd0; a_cmd_valid = 1'b0;
      b_cmd = 4'd0; b_cmd_valid = 1'b0;
      for (int i = 0; i < 64; i++) begin
         rom_a[i] = 8'(i);
         rom_b[i] = 10'(1023 - i);
         bpix[i]  = 1023 - i;
      end

      // Load, immediate WRITE: D equals A
      do_reset(3);
      a_write();
      chk("wr_identity_63", 32'(cap_a[63]), 32'd63);

      // Instance B: MIN at origin (7,1)
      b_exec(CMD_MIN);
      bpix[23] = 983; bpix[24] = 983; bpix[39] = 983; bpix[40] = 983;
      b_write();
      chk("b_min_23", 32'(cap_b[23]), 32'd983);
      chk("b_min_40", 32'(cap_b[40]), 32'd983);
      // cmd_valid held high: one LEFT per busy=0 sample
      @(negedge clk);
      b_cmd = CMD_LEFT;
      b_cmd_valid = 1'b1;
      for (int e = 0; e < 6; e++) begin
         @(posedge clk);
         #1;
         chk("b_hold_busy", 32'(b_busy), (e % 2 == 0) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      b_cmd_valid = 1'b0;
      b_exec(CMD_MIN);  // origin now (4,1): pixels 20,21,36,37
      bpix[20] = 986; bpix[21] = 986; bpix[36] = 986; bpix[37] = 986;
      b_write();
      chk("b_hold_min_20", 32'(cap_b[20]), 32'd986);

      // MAX at origin (3,3)
      a_exec(5);
      a_write();
      chk("max_27", 32'(cap_a[27]), 32'd36);
      chk("max_35", 32'(cap_a[35]), 32'd36);

      // AVG on fresh load
      do_reset(3);
      a_exec(7);
      a_write();
      chk("avg_28", 32'(cap_a[28]), 32'd31);
      chk("avg_36", 32'(cap_a[36]), 32'd31);

      // UP x4 clamps at y0=0
      do_reset(2);
      for (int i = 0; i < 4; i++) a_exec(1);
      a_exec(5);
      a_write();
      chk("up_clamp_3", 32'(cap_a[3]), 32'd12);
      chk("up_clamp_11", 32'(cap_a[11]), 32'd12);
      chk("up_clamp_27", 32'(cap_a[27]), 32'd27);

      // RIGHT x6 clamps at x0=6
      do_reset(2);
      for (int i = 0; i < 6; i++) a_exec(4);
      a_exec(5);
      a_write();
      chk("right_clamp_30", 32'(cap_a[30]), 32'd39);
      chk("right_clamp_31", 32'(cap_a[31]), 32'd39);

      // Rotations, invert, mirror
      do_reset(2);
      a_exec(9);
      a_exec(8);
      a_write();
      chk("rot_back_28", 32'(cap_a[28]), 32'd28);
      chk("rot_back_35", 32'(cap_a[35]), 32'd35);
      a_exec(13);
      a_write();
      chk("inv_27", 32'(cap_a[27]), 32'd228);
      chk("inv_36", 32'(cap_a[36]), 32'd219);
      a_exec(13);
      a_exec(10);
      a_write();
      chk("mirx_27", 32'(cap_a[27]), 32'd35);
      chk("mirx_36", 32'(cap_a[36]), 32'd28);

      // Reset during STORE beat 20
      @(negedge clk);
      a_cmd = CMD_WRITE;
      a_cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      a_cmd_valid = 1'b0;
      for (int i = 0; i <= 20; i++) begin
         @(posedge clk);
         #1;
         chk("abort_beat", 32'({a_iram_valid, a_iram_a}), 32'({1'b1, 6'(i)}));
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_valid", 32'({a_iram_valid, a_busy}), 32'b01);
      do_reset(2);
      a_write();

      // Random images and command streams against the model
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 64; i++) rom_a[i] = 8'($urandom_range(255, 0));
         do_reset(2);
         for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 12; i++) a_exec(int'($urandom_range(15, 1)));
            a_write();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
